// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_pkg
// Brief    : Shared types and constants for the ARM pipeline hazard control.
// Revision : 1.0
// ============================================================================
package arm_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } fsm_state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;
    localparam logic [3:0] REG_PC  = 4'd15;

    // The younger MEM result wins over WB; the PC is always read from the core.
    function automatic logic [1:0] fwd_select(
        input logic [3:0] src,
        input logic       mem_wb_en,
        input logic [3:0] mem_dest,
        input logic       wb_wb_en,
        input logic [3:0] wb_dest
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (src != REG_PC) begin
            if (mem_wb_en && (src == mem_dest)) begin
                sel = FWD_MEM;
            end else if (wb_wb_en && (src == wb_dest)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Brief    : Combinational RAW compare of the ID sources against EXE/MEM
//            destinations. Macro FORWARDING_EN limits stalls to load-use.
// Revision : 1.0
// ============================================================================
module hazard_detect
    import arm_pkg::*;
(
    input  logic [3:0] i_id_src1,
    input  logic [3:0] i_id_src2,
    input  logic       i_id_two_src,
    input  logic       i_id_src1_vld,
    input  logic       i_exe_wb_en,
    input  logic [3:0] i_exe_dest,
    input  logic       i_exe_mem_r_en,
    input  logic       i_mem_wb_en,
    input  logic [3:0] i_mem_dest,
    output logic       o_stall
);

    logic w_hit_exe;
    logic w_hit_mem;

    assign w_hit_exe = (i_id_src1_vld && (i_id_src1 == i_exe_dest)) ||
                       (i_id_two_src  && (i_id_src2 == i_exe_dest));
    assign w_hit_mem = (i_id_src1_vld && (i_id_src1 == i_mem_dest)) ||
                       (i_id_two_src  && (i_id_src2 == i_mem_dest));

`ifdef FORWARDING_EN
    logic w_unused_nofwd;
    assign o_stall        = w_hit_exe && i_exe_mem_r_en;
    assign w_unused_nofwd = ^{i_exe_wb_en, i_mem_wb_en, w_hit_mem};
`else
    logic w_unused_fwd;
    assign o_stall      = (w_hit_exe && i_exe_wb_en) || (w_hit_mem && i_mem_wb_en);
    assign w_unused_fwd = i_exe_mem_r_en;
`endif

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Freeze/flush/bubble sequencer for the 5-stage ARM pipeline.
//            Macro FORWARDING_EN enables the EXE operand-forwarding selects.
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl
    import arm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       i_id_src1,
    input  logic [3:0]       i_id_src2,
    input  logic             i_id_two_src,
    input  logic             i_id_src1_vld,
    input  logic [3:0]       i_exe_src1,
    input  logic [3:0]       i_exe_src2,
    input  logic             i_exe_wb_en,
    input  logic [3:0]       i_exe_dest,
    input  logic             i_exe_mem_r_en,
    input  logic             i_mem_wb_en,
    input  logic [3:0]       i_mem_dest,
    input  logic             i_wb_wb_en,
    input  logic [3:0]       i_wb_dest,
    input  logic             i_branch_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_freeze_front,
    output logic             o_bubble_id,
    output logic             o_flush,
    output logic             o_freeze_all,
    output logic [1:0]       o_fwd_sel1,
    output logic [1:0]       o_fwd_sel2,
    output logic             o_mem_timeout_err,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int                WCNT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] c_wait_max = WCNT_W'(MEM_TIMEOUT);

    fsm_state_t        r_state;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic              r_pend_flush;
    logic              r_bt_prev;
    logic              r_timeout_err;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_hazard;
    logic              w_freeze_all;
    logic              w_flush;
    logic              w_stall;
    logic              w_bt_rise;
    logic [WCNT_W-1:0] w_wait_nxt;

    hazard_detect u_hazard_detect (
        .i_id_src1      (i_id_src1),
        .i_id_src2      (i_id_src2),
        .i_id_two_src   (i_id_two_src),
        .i_id_src1_vld  (i_id_src1_vld),
        .i_exe_wb_en    (i_exe_wb_en),
        .i_exe_dest     (i_exe_dest),
        .i_exe_mem_r_en (i_exe_mem_r_en),
        .i_mem_wb_en    (i_mem_wb_en),
        .i_mem_dest     (i_mem_dest),
        .o_stall        (w_hazard)
    );

    // Edge-detect the branch so one held across a freeze flushes only once.
    assign w_bt_rise = i_branch_taken && !r_bt_prev;

    always_comb begin
        w_freeze_all = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            RUN: begin
                w_freeze_all = i_mem_req && !i_mem_ready;
                w_flush      = !w_freeze_all && (r_pend_flush || w_bt_rise);
            end
            MEM_WAIT: begin
                w_freeze_all = !i_mem_ready;
            end
            default: begin
                w_freeze_all = 1'b0;
            end
        endcase
    end

    assign w_stall    = !w_freeze_all && !w_flush && w_hazard;
    assign w_wait_nxt = (r_wait_cnt == c_wait_max) ? r_wait_cnt : r_wait_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_pend_flush  <= 1'b0;
            r_bt_prev     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            r_bt_prev <= i_branch_taken;

            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            if (w_flush) begin
                r_pend_flush <= 1'b0;
            end else if (w_bt_rise && (w_freeze_all || (r_state == MEM_WAIT))) begin
                r_pend_flush <= 1'b1;
            end

            // The wait counter includes the entry cycle; the error is sticky.
            if (w_freeze_all) begin
                r_state    <= MEM_WAIT;
                r_wait_cnt <= w_wait_nxt;
                if (w_wait_nxt == c_wait_max) begin
                    r_timeout_err <= 1'b1;
                end
            end else begin
                r_state    <= RUN;
                r_wait_cnt <= '0;
            end
        end
    end

    assign o_freeze_all      = !rst && w_freeze_all;
    assign o_flush           = !rst && w_flush;
    assign o_freeze_front    = !rst && w_stall;
    assign o_bubble_id       = !rst && w_stall;
    assign o_mem_timeout_err = r_timeout_err;
    assign o_stall_cnt       = r_stall_cnt;

`ifdef FORWARDING_EN
    assign o_fwd_sel1 = rst ? FWD_REG :
                        fwd_select(i_exe_src1, i_mem_wb_en, i_mem_dest, i_wb_wb_en, i_wb_dest);
    assign o_fwd_sel2 = rst ? FWD_REG :
                        fwd_select(i_exe_src2, i_mem_wb_en, i_mem_dest, i_wb_wb_en, i_wb_dest);
`else
    logic w_unused_fwd;
    assign o_fwd_sel1   = FWD_REG;
    assign o_fwd_sel2   = FWD_REG;
    assign w_unused_fwd = ^{i_exe_src1, i_exe_src2, i_wb_wb_en, i_wb_dest};
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Self-checking bench for pipe_hazard_ctrl (vector table, directed
//            multi-cycle sequences, randomized run against a reference model).
// Revision : 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT = 64;
    localparam int CNT_W       = 16;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [3:0] id_src1;
        logic [3:0] id_src2;
        logic       id_two_src;
        logic       id_src1_vld;
        logic [3:0] exe_src1;
        logic [3:0] exe_src2;
        logic       exe_wb_en;
        logic [3:0] exe_dest;
        logic       exe_mem_r_en;
        logic       mem_wb_en;
        logic [3:0] mem_dest;
        logic       wb_wb_en;
        logic [3:0] wb_dest;
        logic       branch_taken;
        logic       mem_req;
        logic       mem_ready;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic       stall_nf;
        logic       stall_f;
        logic [1:0] fwd1;
        logic [1:0] fwd2;
    } vec_t;

    typedef struct packed {
        logic             ff;
        logic             bub;
        logic             fl;
        logic             fa;
        logic [1:0]       f1;
        logic [1:0]       f2;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    in_t              cur;
    logic             o_freeze_front, o_bubble_id, o_flush, o_freeze_all;
    logic [1:0]       o_fwd_sel1, o_fwd_sel2;
    logic             o_mem_timeout_err;
    logic [CNT_W-1:0] o_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit m_wait, m_err, m_pend, m_btp;
    int m_len, m_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_id_src1         (cur.id_src1),
        .i_id_src2         (cur.id_src2),
        .i_id_two_src      (cur.id_two_src),
        .i_id_src1_vld     (cur.id_src1_vld),
        .i_exe_src1        (cur.exe_src1),
        .i_exe_src2        (cur.exe_src2),
        .i_exe_wb_en       (cur.exe_wb_en),
        .i_exe_dest        (cur.exe_dest),
        .i_exe_mem_r_en    (cur.exe_mem_r_en),
        .i_mem_wb_en       (cur.mem_wb_en),
        .i_mem_dest        (cur.mem_dest),
        .i_wb_wb_en        (cur.wb_wb_en),
        .i_wb_dest         (cur.wb_dest),
        .i_branch_taken    (cur.branch_taken),
        .i_mem_req         (cur.mem_req),
        .i_mem_ready       (cur.mem_ready),
        .o_freeze_front    (o_freeze_front),
        .o_bubble_id       (o_bubble_id),
        .o_flush           (o_flush),
        .o_freeze_all      (o_freeze_all),
        .o_fwd_sel1        (o_fwd_sel1),
        .o_fwd_sel2        (o_fwd_sel2),
        .o_mem_timeout_err (o_mem_timeout_err),
        .o_stall_cnt       (o_stall_cnt)
    );

    function automatic in_t idle();
        in_t v;
        v = '0;
        return v;
    endfunction

    function automatic in_t hz(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                               input logic vld, input logic [3:0] ed, input logic ewb,
                               input logic eld, input logic [3:0] md, input logic mwb);
        in_t v;
        v = idle();
        v.id_src1 = s1; v.id_src2 = s2; v.id_two_src = two; v.id_src1_vld = vld;
        v.exe_dest = ed; v.exe_wb_en = ewb; v.exe_mem_r_en = eld;
        v.mem_dest = md; v.mem_wb_en = mwb;
        v.exe_src1 = 4'd15; v.exe_src2 = 4'd15;
        return v;
    endfunction

    function automatic in_t fw(input logic [3:0] es1, input logic [3:0] es2, input logic [3:0] md,
                               input logic mwb, input logic [3:0] wd, input logic wwb);
        in_t v;
        v = idle();
        v.exe_src1 = es1; v.exe_src2 = es2;
        v.mem_dest = md; v.mem_wb_en = mwb; v.wb_dest = wd; v.wb_wb_en = wwb;
        return v;
    endfunction

    function automatic vec_t mkv(input in_t v, input logic snf, input logic sf,
                                 input logic [1:0] f1, input logic [1:0] f2);
        vec_t r;
        r.in = v; r.stall_nf = snf; r.stall_f = sf; r.fwd1 = f1; r.fwd2 = f2;
        return r;
    endfunction

    function automatic bit reads(input in_t v, input logic [3:0] d);
        return (v.id_src1_vld && v.id_src1 == d) || (v.id_two_src && v.id_src2 == d);
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [3:0] s, input in_t v);
`ifdef FORWARDING_EN
        if (s == 4'd15) return 2'b00;
        if (v.mem_wb_en && s == v.mem_dest) return 2'b01;
        if (v.wb_wb_en && s == v.wb_dest) return 2'b10;
`endif
        return 2'b00;
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        bit fa, rise, fl, haz;
        fa   = !cur.mem_ready && (m_wait || cur.mem_req);
        rise = cur.branch_taken && !m_btp;
        fl   = !fa && !m_wait && (m_pend || rise);
`ifdef FORWARDING_EN
        haz = cur.exe_mem_r_en && reads(cur, cur.exe_dest);
`else
        haz = (cur.exe_wb_en && reads(cur, cur.exe_dest)) ||
              (cur.mem_wb_en && reads(cur, cur.mem_dest));
`endif
        e.ff  = !rst && !fa && !fl && haz;
        e.bub = e.ff;
        e.fl  = !rst && fl;
        e.fa  = !rst && fa;
        e.f1  = rst ? 2'b00 : ref_fwd(cur.exe_src1, cur);
        e.f2  = rst ? 2'b00 : ref_fwd(cur.exe_src2, cur);
        e.err = m_err;
        e.cnt = m_cnt[CNT_W-1:0];
        return e;
    endfunction

    task automatic model_update();
        exp_t e;
        bit rise;
        if (rst) begin
            m_wait = 0; m_len = 0; m_err = 0; m_pend = 0; m_btp = 0; m_cnt = 0;
        end else begin
            e    = model_exp();
            rise = cur.branch_taken && !m_btp;
            if (e.ff && m_cnt < CNT_MAX) m_cnt++;
            if (e.fl) m_pend = 0;
            else if (rise && (e.fa || m_wait)) m_pend = 1;
            m_btp  = cur.branch_taken;
            m_wait = e.fa;
            m_len  = e.fa ? m_len + 1 : 0;
            if (m_len >= MEM_TIMEOUT) m_err = 1;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ctl();
        return {o_freeze_front, o_bubble_id, o_flush, o_freeze_all};
    endfunction

    task automatic apply(input in_t v, input logic r);
        cur = v;
        rst = r;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step_ctl(input string nm, input in_t v, input logic [3:0] exp);
        apply(v, 1'b0);
        check(nm, {28'd0, ctl()}, {28'd0, exp});
        advance();
    endtask

    task automatic do_reset();
        apply(idle(), 1'b1);
        advance();
    endtask

    function automatic logic [3:0] pick();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'd15 : 4'(r);
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[16];
        in_t  h, mh, m, a, b, v;
        exp_t e, act;
        int   exp_stalls;
        logic s;

        vt[0]  = mkv(hz(4'd2, 4'd0, 0, 1, 4'd2, 1, 0, 4'd0, 0), 1, 0, 2'b00, 2'b00);
        vt[1]  = mkv(hz(4'd2, 4'd0, 0, 1, 4'd2, 1, 1, 4'd0, 0), 1, 1, 2'b00, 2'b00);
        vt[2]  = mkv(hz(4'd2, 4'd0, 0, 0, 4'd2, 1, 1, 4'd0, 0), 0, 0, 2'b00, 2'b00);
        vt[3]  = mkv(hz(4'd0, 4'd7, 1, 0, 4'd7, 1, 1, 4'd0, 0), 1, 1, 2'b00, 2'b00);
        vt[4]  = mkv(hz(4'd0, 4'd7, 0, 0, 4'd7, 1, 1, 4'd0, 0), 0, 0, 2'b00, 2'b00);
        vt[5]  = mkv(hz(4'd4, 4'd0, 0, 1, 4'd9, 1, 0, 4'd4, 1), 1, 0, 2'b00, 2'b00);
        vt[6]  = mkv(hz(4'd4, 4'd0, 0, 1, 4'd9, 1, 0, 4'd4, 0), 0, 0, 2'b00, 2'b00);
        vt[7]  = mkv(hz(4'd4, 4'd0, 0, 1, 4'd5, 1, 1, 4'd6, 1), 0, 0, 2'b00, 2'b00);
        vt[8]  = mkv(hz(4'd1, 4'd9, 1, 1, 4'd5, 1, 0, 4'd9, 1), 1, 0, 2'b00, 2'b00);
        vt[9]  = mkv(hz(4'd3, 4'd3, 1, 1, 4'd3, 1, 0, 4'd0, 0), 1, 0, 2'b00, 2'b00);
        vt[10] = mkv(fw(4'd3, 4'd8, 4'd3, 1, 4'd8, 1), 0, 0, 2'b01, 2'b10);
        vt[11] = mkv(fw(4'd3, 4'd3, 4'd3, 1, 4'd3, 1), 0, 0, 2'b01, 2'b01);
        vt[12] = mkv(fw(4'd15, 4'd6, 4'd15, 1, 4'd15, 1), 0, 0, 2'b00, 2'b00);
        vt[13] = mkv(fw(4'd6, 4'd6, 4'd6, 0, 4'd6, 1), 0, 0, 2'b10, 2'b10);
        vt[14] = mkv(fw(4'd0, 4'd1, 4'd0, 1, 4'd2, 1), 0, 0, 2'b01, 2'b00);
        vt[15] = mkv(fw(4'd5, 4'd5, 4'd5, 1, 4'd5, 0), 0, 0, 2'b01, 2'b01);

        cur = idle();
        rst = 1'b1;
        do_reset();
        do_reset();

        // reset state, with hazard/forward-inducing inputs held during reset
        h = hz(4'd2, 4'd0, 0, 1, 4'd2, 1, 1, 4'd0, 0);
        v = vt[10].in;
        v.id_src1 = 4'd2; v.id_src1_vld = 1; v.exe_dest = 4'd2; v.exe_wb_en = 1; v.exe_mem_r_en = 1;
        v.mem_req = 1;
        apply(v, 1'b1);
        check("reset_outputs", {24'd0, ctl(), o_fwd_sel1, o_fwd_sel2}, 32'd0);
        advance();
        apply(idle(), 1'b0);
        check("reset_err_cnt", {15'd0, o_mem_timeout_err, o_stall_cnt}, 32'd0);
        advance();

        // vector table
        exp_stalls = 0;
        for (int i = 0; i < 16; i++) begin
`ifdef FORWARDING_EN
            s = vt[i].stall_f;
            apply(vt[i].in, 1'b0);
            check($sformatf("vec%0d_fwd", i), {28'd0, o_fwd_sel1, o_fwd_sel2},
                  {28'd0, vt[i].fwd1, vt[i].fwd2});
`else
            s = vt[i].stall_nf;
            apply(vt[i].in, 1'b0);
            check($sformatf("vec%0d_fwd", i), {28'd0, o_fwd_sel1, o_fwd_sel2}, 32'd0);
`endif
            check($sformatf("vec%0d_ctl", i), {28'd0, ctl()}, {28'd0, s, s, 2'b00});
            if (s) exp_stalls++;
            advance();
        end
        apply(idle(), 1'b0);
        check("vec_stall_cnt", {16'd0, o_stall_cnt}, 32'(exp_stalls));
        advance();

        // single RAW stall
        do_reset();
        step_ctl("t1_stall", h, 4'b1100);
        apply(idle(), 1'b0);
        check("t1_after", {28'd0, ctl()}, 32'd0);
        check("t1_cnt", {16'd0, o_stall_cnt}, 32'd1);
        advance();

        // ALU result consumed next cycle vs load-use
        do_reset();
        a = hz(4'd3, 4'd0, 0, 1, 4'd3, 1, 0, 4'd0, 0);
`ifdef FORWARDING_EN
        step_ctl("t2_alu_use", a, 4'b0000);
        apply(fw(4'd3, 4'd0, 4'd3, 1, 4'd0, 0), 1'b0);
        check("t2_fwd_next", {30'd0, o_fwd_sel1}, 32'd1);
`else
        step_ctl("t2_alu_use", a, 4'b1100);
        apply(fw(4'd3, 4'd0, 4'd3, 1, 4'd0, 0), 1'b0);
        check("t2_fwd_next", {30'd0, o_fwd_sel1}, 32'd0);
`endif
        advance();
        a.exe_mem_r_en = 1;
        step_ctl("t2_load_use", a, 4'b1100);

        // three-cycle memory wait, hazard present but masked
        do_reset();
        mh = h; mh.mem_req = 1; mh.mem_ready = 0;
        step_ctl("t3_entry", mh, 4'b0001);
        step_ctl("t3_wait1", mh, 4'b0001);
        step_ctl("t3_wait2", mh, 4'b0001);
        m = idle(); m.mem_req = 1; m.mem_ready = 1;
        step_ctl("t3_exit", m, 4'b0000);
        step_ctl("t3_run", idle(), 4'b0000);
        step_ctl("t3_run_hz", h, 4'b1100);

        // branch in the wait entry cycle, held across the freeze
        do_reset();
        m = idle(); m.mem_req = 1; m.branch_taken = 1;
        step_ctl("t4_entry", m, 4'b0001);
        step_ctl("t4_wait1", m, 4'b0001);
        step_ctl("t4_wait2", m, 4'b0001);
        m.mem_ready = 1;
        step_ctl("t4_exit", m, 4'b0000);
        b = h; b.branch_taken = 1;
        step_ctl("t4_flush", b, 4'b0010);
        step_ctl("t4_no_2nd", b, 4'b1100);
        step_ctl("t4_idle", idle(), 4'b0000);

        // memory timeout
        do_reset();
        m = idle(); m.mem_req = 1;
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
            apply(m, 1'b0);
            if (k == 0 || k == MEM_TIMEOUT - 1)
                check($sformatf("t5_wait%0d", k), {30'd0, o_mem_timeout_err, o_freeze_all}, 32'd1);
            advance();
        end
        apply(m, 1'b0);
        check("t5_err_set", {30'd0, o_mem_timeout_err, o_freeze_all}, 32'd3);
        advance();
        m.mem_ready = 1;
        apply(m, 1'b0);
        advance();
        for (int k = 0; k < 3; k++) begin
            apply(idle(), 1'b0);
            advance();
        end
        apply(idle(), 1'b0);
        check("t5_sticky", {31'd0, o_mem_timeout_err}, 32'd1);
        advance();
        do_reset();
        apply(idle(), 1'b0);
        check("t5_cleared", {31'd0, o_mem_timeout_err}, 32'd0);
        advance();

        // reset mid-wait with a pending flush
        do_reset();
        step_ctl("t6_stall", h, 4'b1100);
        m = idle(); m.mem_req = 1; m.branch_taken = 1;
        step_ctl("t6_entry", m, 4'b0001);
        step_ctl("t6_wait", m, 4'b0001);
        apply(m, 1'b1);
        check("t6_in_rst", {28'd0, ctl()}, 32'd0);
        advance();
        apply(idle(), 1'b0);
        check("t6_after_rst", {7'd0, ctl(), o_fwd_sel1, o_fwd_sel2, o_mem_timeout_err, o_stall_cnt}, 32'd0);
        advance();
        step_ctl("t6_no_flush1", idle(), 4'b0000);
        step_ctl("t6_no_flush2", idle(), 4'b0000);

        // randomized run against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            v = idle();
            v.id_src1      = pick();
            v.id_src2      = pick();
            v.id_two_src   = 1'($urandom_range(0, 1));
            v.id_src1_vld  = 1'($urandom_range(0, 1));
            v.exe_src1     = pick();
            v.exe_src2     = pick();
            v.exe_wb_en    = 1'($urandom_range(0, 1));
            v.exe_dest     = pick();
            v.exe_mem_r_en = 1'($urandom_range(0, 1));
            v.mem_wb_en    = 1'($urandom_range(0, 1));
            v.mem_dest     = pick();
            v.wb_wb_en     = 1'($urandom_range(0, 1));
            v.wb_dest      = pick();
            v.branch_taken = ($urandom_range(0, 5) == 0);
            v.mem_req      = ($urandom_range(0, 3) == 0);
            v.mem_ready    = ($urandom_range(0, 2) != 0);
            apply(v, ($urandom_range(0, 249) == 0));
            e   = model_exp();
            act = {o_freeze_front, o_bubble_id, o_flush, o_freeze_all,
                   o_fwd_sel1, o_fwd_sel2, o_mem_timeout_err, o_stall_cnt};
            check($sformatf("rand%0d", n), 32'(act), 32'(e));
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
